// File: rtl/segway_pkg.sv
// segway_pkg: shared state type, rider-weight defaults and timer widths for steer_en
package segway_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, STEER_EN = 2'd2} steer_state_t;
    localparam logic [11:0] DFLT_MIN_RIDER_WT = 12'h200;
    localparam logic [11:0] DFLT_WT_HYST = 12'h040;
    localparam int TMR_W_FULL = 26;
    localparam int TMR_W_FAST = 15;
endpackage

// File: rtl/steer_en_if.sv
// steer_en_if: load-cell input strobe/data and rider/steering status outputs
interface steer_en_if;
    logic vld;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic en_steer;
    logic rider_off;
    modport master (output vld, lft_ld, rght_ld, input en_steer, rider_off);
    modport slave (input vld, lft_ld, rght_ld, output en_steer, rider_off);
endinterface

// File: rtl/steer_en_sm.sv
// steer_en_sm: rider/steering Moore FSM with saturating balance timer
module steer_en_sm
    import segway_pkg::*;
#(
    parameter int W = TMR_W_FULL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_on_ok,
    input  logic i_off_det,
    input  logic i_diff_gt_1_4,
    input  logic i_diff_gt_15_16,
    output logic o_en_steer,
    output logic o_rider_off
);
    steer_state_t r_state, w_nxt;
    logic [W-1:0] r_tmr;
    logic w_clr, w_inc, w_full;

    assign w_full = &r_tmr;

    // off_det is tested first in every rider-present state so it beats imbalance
    always_comb begin
        w_nxt = IDLE;
        w_clr = 1'b0;
        w_inc = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt = i_on_ok ? WAIT : IDLE;
                w_clr = i_on_ok;
            end
            WAIT: begin
                w_nxt = i_off_det ? IDLE : (!i_diff_gt_1_4 && w_full) ? STEER_EN : WAIT;
                w_clr = !i_off_det && i_diff_gt_1_4;
                w_inc = !i_off_det && !i_diff_gt_1_4 && !w_full;
            end
            STEER_EN: begin
                w_nxt = i_off_det ? IDLE : i_diff_gt_15_16 ? WAIT : STEER_EN;
                w_clr = !i_off_det && i_diff_gt_15_16;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tmr <= '0;
        end else begin
            r_state <= w_nxt;
            r_tmr <= w_clr ? '0 : w_inc ? r_tmr + W'(1) : r_tmr;
        end
    end

    assign o_en_steer = r_state == STEER_EN;
    assign o_rider_off = r_state == IDLE;
endmodule

// File: rtl/steer_en.sv
// steer_en: latches load-cell readings and qualifies rider presence and steering enable
module steer_en
    import segway_pkg::*;
#(
    parameter logic [11:0] MIN_RIDER_WT = DFLT_MIN_RIDER_WT,
    parameter logic [11:0] WT_HYST = DFLT_WT_HYST,
    parameter bit FAST_SIM = 1'b0
) (
    input logic clk,
    input logic rst_n,
    steer_en_if.slave bus
);
    localparam int W = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;
    localparam logic [12:0] ON_TH = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYST};
    localparam logic [12:0] OFF_TH = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYST};

    logic [11:0] r_lft_q, r_rght_q;
    logic [12:0] w_sum, w_diff;
    logic w_on_ok, w_off_det, w_diff_gt_1_4, w_diff_gt_15_16;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_q <= '0;
            r_rght_q <= '0;
        end else if (bus.vld) begin
            r_lft_q <= bus.lft_ld;
            r_rght_q <= bus.rght_ld;
        end
    end

    // 13-bit sum of two 12-bit loads cannot overflow; diff never exceeds sum
    assign w_sum = {1'b0, r_lft_q} + {1'b0, r_rght_q};
    assign w_diff = (r_lft_q >= r_rght_q) ? {1'b0, r_lft_q - r_rght_q} : {1'b0, r_rght_q - r_lft_q};
    assign w_on_ok = w_sum >= ON_TH;
    assign w_off_det = w_sum < OFF_TH;
    assign w_diff_gt_1_4 = w_diff > (w_sum >> 2);
    assign w_diff_gt_15_16 = w_diff > (w_sum - (w_sum >> 4));

    steer_en_sm #(.W(W)) u_sm (
        .clk(clk),
        .rst_n(rst_n),
        .i_on_ok(w_on_ok),
        .i_off_det(w_off_det),
        .i_diff_gt_1_4(w_diff_gt_1_4),
        .i_diff_gt_15_16(w_diff_gt_15_16),
        .o_en_steer(bus.en_steer),
        .o_rider_off(bus.rider_off)
    );
endmodule

// File: tb/tb_steer_en.sv
// tb_steer_en: directed, table-driven and random checks of steer_en against a rule-level model
module tb_steer_en;
    import segway_pkg::*;

    localparam int FULL_CNT = 1 << TMR_W_FAST;
    localparam int ON_TH = int'(DFLT_MIN_RIDER_WT) + int'(DFLT_WT_HYST);
    localparam int OFF_TH = int'(DFLT_MIN_RIDER_WT) - int'(DFLT_WT_HYST);

    typedef struct {
        logic v;
        logic [11:0] l;
        logic [11:0] r;
        logic en;
        logic off;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int m_ph, m_cnt, m_lq, m_rq;
    vec_t tbl[18];

    steer_en_if u_if();

    steer_en #(.FAST_SIM(1'b1)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(u_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph = 0;
        m_cnt = 0;
        m_lq = 0;
        m_rq = 0;
    endtask

    // phase 0 = no rider, 1 = waiting for balance, 2 = steering; m_cnt = balanced edges while waiting
    task automatic model_edge();
        int s, d;
        s = m_lq + m_rq;
        d = (m_lq > m_rq) ? m_lq - m_rq : m_rq - m_lq;
        if (m_ph == 0) begin
            if (s >= ON_TH) begin
                m_ph = 1;
                m_cnt = 0;
            end
        end else if (s < OFF_TH) begin
            m_ph = 0;
        end else if (m_ph == 1) begin
            if (d > s / 4) m_cnt = 0;
            else begin
                m_cnt++;
                if (m_cnt == FULL_CNT) m_ph = 2;
            end
        end else if (d > s - s / 16) begin
            m_ph = 1;
            m_cnt = 0;
        end
        if (u_if.vld) begin
            m_lq = int'(u_if.lft_ld);
            m_rq = int'(u_if.rght_ld);
        end
    endtask

    task automatic step(input logic v, input logic [11:0] l, input logic [11:0] r);
        u_if.vld = v;
        u_if.lft_ld = l;
        u_if.rght_ld = r;
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check("model_en_steer", u_if.en_steer, m_ph == 2);
        check("model_rider_off", u_if.rider_off, m_ph == 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, u_if.lft_ld, u_if.rght_ld);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 12'h200, 12'h060, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 12'h200, 12'h060, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 12'h250, 12'h010, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 12'h250, 12'h010, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 12'h250, 12'h010, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 12'h0D8, 12'h0D8, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 12'h0D8, 12'h0D8, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 12'h100, 12'h100, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 12'h100, 12'h100, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 12'h100, 12'h100, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 12'h120, 12'h120, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 12'h120, 12'h120, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 12'h0E0, 12'h0E0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 12'h0E0, 12'h0E0, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 12'h1A0, 12'h010, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 12'h1A0, 12'h010, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 12'h11F, 12'h120, 1'b0, 1'b1};
        tbl[17] = '{1'b0, 12'h11F, 12'h120, 1'b0, 1'b1};

        model_reset();
        u_if.vld = 1'b0;
        u_if.lft_ld = '0;
        u_if.rght_ld = '0;
        #2;
        check("reset_rider_off", u_if.rider_off, 1'b1);
        check("reset_en_steer", u_if.en_steer, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(3);

        // mount, then reset in the middle of the balance count
        step(1'b1, 12'h130, 12'h130);
        check("mount_vld_edge_rider_off", u_if.rider_off, 1'b1);
        step(1'b0, 12'h130, 12'h130);
        check("mount_rider_off_fall", u_if.rider_off, 1'b0);
        run(16000);
        rst_n = 1'b0;
        #1;
        check("async_rst_rider_off", u_if.rider_off, 1'b1);
        check("async_rst_en_steer", u_if.en_steer, 1'b0);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rst_hold_rider_off", u_if.rider_off, 1'b1);
            check("rst_hold_en_steer", u_if.en_steer, 1'b0);
        end
        rst_n = 1'b1;
        run(50);
        check("post_rst_no_vld_idle", u_if.rider_off, 1'b1);

        // restart count, imbalance at 20000, restore and count the full period
        step(1'b1, 12'h130, 12'h130);
        run(20000);
        check("wait_20000_en_low", u_if.en_steer, 1'b0);
        step(1'b1, 12'h1C0, 12'h0A0);
        run(100);
        check("imbalance_en_low", u_if.en_steer, 1'b0);
        check("imbalance_rider_on", u_if.rider_off, 1'b0);
        step(1'b1, 12'h130, 12'h130);
        run(FULL_CNT - 1);
        check("restore_en_not_early", u_if.en_steer, 1'b0);
        step(1'b0, 12'h130, 12'h130);
        check("restore_en_on_time", u_if.en_steer, 1'b1);

        // tolerance, 15/16 drop, dismount, hysteresis and threshold boundaries
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].v, tbl[i].l, tbl[i].r);
            n_chk++;
            if (u_if.en_steer !== tbl[i].en || u_if.rider_off !== tbl[i].off) begin
                n_fail++;
                $display("FAIL tbl[%0d]: en_steer=%b rider_off=%b expected en_steer=%b rider_off=%b",
                         i, u_if.en_steer, u_if.rider_off, tbl[i].en, tbl[i].off);
            end
        end

        // random loads straddling the thresholds
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 12'($urandom_range(0, 'h180)), 12'($urandom_range(0, 'h180)));
            else
                step(1'b0, u_if.lft_ld, u_if.rght_ld);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/steer_en.md
Name: steer_en

Overview:
- Rider-presence and steering-enable qualifier inside the Segway DUT.
- Consumes left and right load-cell readings produced by the A2D interface, which polls the ADC128S over SPI.
- Drives `en_steer` into the balance controller and `rider_off` into the power/piezo logic.
- Steering is enabled only after the rider has stood balanced on the platform for about 1.34 s. It is disabled when the loads become grossly unequal or the rider steps off.

Parameters:
- `MIN_RIDER_WT`, 12'h200, nominal sum `lft_ld + rght_ld` that means a rider is present.
- `WT_HYST`, 12'h040, hysteresis around `MIN_RIDER_WT`. Rider-on threshold is MIN+HYST; rider-off threshold is MIN−HYST.
- `FAST_SIM`, 1'b0, selects the timer width. 0 gives W=26 (2^26 clk, about 1.34 s at 50 MHz). 1 gives W=15 for simulation.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous active-low reset.
- `vld` input 1: one-cycle strobe; the load values on this cycle are new.
- `lft_ld` input 12: left load cell, unsigned.
- `rght_ld` input 12: right load cell, unsigned.
- `en_steer` output 1: steering enabled.
- `rider_off` output 1: no rider on the platform.

Behaviour:
- Async reset gives: `state`=IDLE, `lft_q`=`rght_q`=0, `tmr`=0, `en_steer`=0, `rider_off`=1.
- Capture:
  - On the clk edge where `vld`=1, `lft_ld` and `rght_ld` are latched into `lft_q` and `rght_q`.
  - When `vld`=0, the latched values hold.
  - All comparisons use the latched values.
- Arithmetic, all unsigned 13-bit with no overflow possible:
  - sum = `lft_q` + `rght_q`.
  - diff = |`lft_q` − `rght_q`|.
  - on_ok = sum ≥ MIN+HYST.
  - off_det = sum < MIN−HYST.
  - diff_gt_1_4 = diff > (sum>>2).
  - diff_gt_15_16 = diff > (sum − (sum>>4)).
- Timer:
  - W-bit up-counter; TMAX = 2^W−1.
  - Cleared on the clear condition; increments when counting; never wraps.
  - tmr_full = (`tmr` == TMAX).
- FSM (Moore; outputs decoded directly from the state register, so they are glitch-free):
  - IDLE: `rider_off`=1, `en_steer`=0.
    - on_ok → WAIT, `tmr` cleared.
    - Otherwise stay.
  - WAIT: `rider_off`=0, `en_steer`=0.
    - off_det → IDLE.
    - Else diff_gt_1_4 → stay, clear `tmr`.
    - Else tmr_full → STEER_EN.
    - Else stay, increment `tmr`.
  - STEER_EN: `rider_off`=0, `en_steer`=1.
    - off_det → IDLE.
    - Else diff_gt_15_16 → WAIT, clear `tmr`.
    - Otherwise stay.
- Priority: off_det beats every imbalance condition.
- Illegal state encoding → IDLE on the next edge.
- Latency:
  - `vld` edge V latches the data. The state change occurs at V+1, so outputs change at V+1.
  - If WAIT is entered at edge E and the loads stay balanced, `en_steer` rises at edge E+2^W.
- Simultaneous events: a `vld` arriving on the same edge the timer saturates uses the old `lft_q`/`rght_q` for that edge's decision.
- Reset mid-count: `tmr` and state return to reset values immediately. No `en_steer` pulse is produced.
- Hysteresis: a sum between MIN−HYST and MIN+HYST−1 does not leave IDLE and does not force IDLE.

Decomposition:
- Package `segway_pkg`:
  - typedef enum `steer_state_t` {IDLE, WAIT, STEER_EN}.
  - `MIN_RIDER_WT` and `WT_HYST` default localparams, shared with the testbench (PLAT/MIN_LOAD constants).
  - `TMR_W_FULL`=26 and `TMR_W_FAST`=15.
- One sub-module, `steer_en_sm`:
  - Contains the FSM and timer.
  - Inputs: on_ok, off_det, diff_gt_1_4, diff_gt_15_16.
- The top level holds the capture registers and the comparison datapath.

Test Plan (FAST_SIM=1, TMAX=32767):
- Reset: assert `rst_n`=0 mid-simulation → `rider_off`=1 and `en_steer`=0 asynchronously, held until release.
- Mount:
  - Stimulus: `lft`=0x130, `rght`=0x130 (sum 0x260) with `vld` at edge V.
  - `rider_off` falls at V+1.
  - `en_steer` rises at V+1+32768 and not before.
- Imbalance during WAIT:
  - Apply `lft`=0x1C0, `rght`=0x0A0 (diff 0x120 > 0x98) at count 20000 → timer clears and `en_steer` stays 0.
  - Restore 0x130/0x130 → `en_steer` rises a full 32768 cycles later.
- Enabled tolerance:
  - In STEER_EN, `lft`=0x200, `rght`=0x060 (diff 0x1A0 ≤ 0x23A) → `en_steer` stays 1.
  - Then `lft`=0x250, `rght`=0x010 (diff 0x240 > 0x23A) → `en_steer` falls one cycle after `vld` and the block is in WAIT.
- Dismount and hysteresis:
  - `lft`=0x0D8, `rght`=0x0D8 (sum 0x1B0 < 0x1C0) from STEER_EN → IDLE, `rider_off`=1, `en_steer`=0.
  - Then sum 0x200 (0x100 each) → remains IDLE.
  - Then sum 0x240 → WAIT.
- Reset mid-count: drop `rst_n` at count 16000, release, keep balanced loads with no new `vld` → block stays IDLE. The next `vld` restarts the full 32768-cycle count.
